tv_sweep_misr: RTL and testbench
================================

Name: tv_sweep_misr

Overview:
- Parametrised, clocked successor to the team's exhaustive combinational test loop.
- Drives every input vector of an IN_W-input combinational DUT in order and waits a programmable settle time per vector.
- Folds each DUT response into a multiple-input signature register (MISR) and flags pass/fail against a golden signature.
- Sits beside the DUT in lab benches and on-board self-test wrappers; replaces hand-written for-loop stimulus.

Parameters:
- IN_W, 3: DUT input width; the sweep covers 2^IN_W vectors (1..16).
- OUT_W, 2: DUT output width; must be <= SIG_W.
- SETTLE, 1: wait cycles between driving a vector and capturing the response (0..15).
- SIG_W, 16: signature width.
- POLY, 16'h1021: MISR feedback polynomial taps, excluding the implicit x^SIG_W term.
- SEED, 0: signature value after reset and at each start.
- GOLDEN, 0: expected final signature.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep
- resp  input  OUT_W  DUT outputs
- stim  output  IN_W  DUT inputs
- vec_idx  output  IN_W  index of the current vector
- busy  output  1  sweep in progress
- done  output  1  sweep complete; held high until the next accepted start
- pass  output  1  done && signature == GOLDEN
- signature  output  SIG_W  current MISR value

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: stim=0, vec_idx=0, busy=0, done=0, pass=0, signature=SEED, FSM=IDLE.
- rst asserted mid-sweep aborts the sweep at the next edge and applies the reset values above; no partial done is reported.
- FSM states: IDLE, APPLY, WAIT, CAPTURE, DONE.
- IDLE: start=1 at edge t -> APPLY. From t+1: busy=1, vec_idx=0, signature=SEED.
- DONE: start=1 behaves as in IDLE. It clears done and pass and restarts the sweep.
- APPLY (1 cycle): stim = f(vec_idx). Go to WAIT if SETTLE>0, else CAPTURE.
- WAIT: a counter runs SETTLE cycles; stim is held stable.
- CAPTURE (1 cycle): the MISR samples resp at the end of this cycle.
  - If vec_idx = 2^IN_W-1 -> DONE.
  - Otherwise vec_idx increments -> APPLY.
- vec_idx never wraps during a sweep.
- Per-vector cost is 2+SETTLE cycles. A full sweep is 2^IN_W*(2+SETTLE) cycles; busy is high for exactly that count.
- DONE: busy=0 and done=1. stim holds the last vector. signature is frozen. pass is registered and valid in the same cycle as done.
- start while busy=1 is ignored.
- MISR update:
  - fb = signature[SIG_W-1]
  - sh = signature << 1 (LSB 0), truncated to SIG_W
  - if fb, sh ^= POLY
  - next = sh ^ zero_extend(resp, SIG_W)
- stim mapping f: stim = vec_idx, binary order, unless the optional feature is enabled.
- The block never reads resp outside CAPTURE.
- Static parameter checks (elaboration-time error): OUT_W > SIG_W, or IN_W outside 1..16.

Optional Feature:
- Macro: TVSWEEP_GRAY_EN.
- Defined: stim = vec_idx ^ (vec_idx >> 1), so only one DUT input toggles between consecutive vectors (glitch/hazard studies). vec_idx still counts in binary. The sweep length is unchanged.
- Undefined: binary stim order; no Gray logic is synthesised.

Test Plan:
- IN_W=3, OUT_W=2, SETTLE=1, resp tied 0, SEED=0, GOLDEN=0; pulse start -> stim steps 0..7, each held 3 cycles. busy is high exactly 24 cycles, then done=1, pass=1, signature=16'h0000.
- IN_W=2, OUT_W=2, SETTLE=0, resp=stim loopback -> signature sequence 0000, 0001, 0000, 0003. Final signature=16'h0003; pass=1 only when GOLDEN=16'h0003.
- Same loopback bench with TVSWEEP_GRAY_EN defined -> stim order 0, 1, 3, 2; final signature=16'h0000.
- Assert rst during vector 4 of a 3-bit sweep -> next cycle busy=0, stim=0, signature=SEED, done=0. A subsequent start completes a normal full sweep.
- Pulse start again mid-sweep -> ignored, and the sweep length is unchanged. Pulse start while done=1 -> done and pass drop, and a new sweep begins.
- IN_W=3, DUT with D=A&B and E=~(D|C), SETTLE=2, GOLDEN set to the model-computed value -> pass=1. Flip one DUT output bit at vector 5 -> pass=0.

Source files
------------

// File: rtl/tv_sweep_misr.sv
`timescale 1ns/1ps
// Exhaustive test-vector sweeper: drives every IN_W-bit vector into a combinational DUT,
// folds each response into a MISR and compares against GOLDEN. Optional macro: TVSWEEP_GRAY_EN.
module tv_sweep_misr #(
    parameter int              IN_W   = 3,
    parameter int              OUT_W  = 2,
    parameter int              SETTLE = 1,
    parameter int              SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = 16'h1021,
    parameter logic [SIG_W-1:0] SEED   = 16'h0000,
    parameter logic [SIG_W-1:0] GOLDEN = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OUT_W-1:0] resp,
    output logic [IN_W-1:0]  stim,
    output logic [IN_W-1:0]  vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    if (OUT_W > SIG_W) begin : g_bad_out_w
        $error("tv_sweep_misr: OUT_W must not exceed SIG_W");
    end
    if (IN_W < 1 || IN_W > 16) begin : g_bad_in_w
        $error("tv_sweep_misr: IN_W must be in 1..16");
    end
    if (SETTLE < 0 || SETTLE > 15) begin : g_bad_settle
        $error("tv_sweep_misr: SETTLE must be in 0..15");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        APPLY   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [IN_W-1:0] VEC_LAST    = {IN_W{1'b1}};
    localparam logic [3:0]      SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] cur,
                                                   input logic [OUT_W-1:0] r);
        logic [SIG_W-1:0] sh;
        logic [SIG_W-1:0] ext;
        sh = cur << 1;
        if (cur[SIG_W-1]) begin
            sh = sh ^ POLY;
        end else begin
            sh = sh;
        end
        ext = {SIG_W{1'b0}};
        ext[OUT_W-1:0] = r;
        return sh ^ ext;
    endfunction

    function automatic logic [IN_W-1:0] stim_map(input logic [IN_W-1:0] v);
`ifdef TVSWEEP_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    state_t           state_r, state_nxt_s;
    logic [IN_W-1:0]  vec_idx_r, vec_nxt_s;
    logic [IN_W-1:0]  stim_r, stim_nxt_s;
    logic [SIG_W-1:0] sig_r, sig_nxt_s;
    logic [3:0]       wait_cnt_r, cnt_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
    logic             pass_r, pass_nxt_s;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_nxt_s = state_r;
        vec_nxt_s   = vec_idx_r;
        stim_nxt_s  = stim_r;
        sig_nxt_s   = sig_r;
        cnt_nxt_s   = wait_cnt_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt_s = APPLY;
                    vec_nxt_s   = {IN_W{1'b0}};
                    stim_nxt_s  = stim_map({IN_W{1'b0}});
                    sig_nxt_s   = SEED;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            APPLY: begin
                cnt_nxt_s = 4'd0;
                if (SETTLE > 0) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = CAPTURE;
                end
            end
            WAIT: begin
                if (wait_cnt_r == SETTLE_LAST) begin
                    state_nxt_s = CAPTURE;
                end else begin
                    cnt_nxt_s = wait_cnt_r + 4'd1;
                end
            end
            CAPTURE: begin
                // resp is only ever sampled here
                sig_nxt_s = misr_step(sig_r, resp);
                if (vec_idx_r == VEC_LAST) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = APPLY;
                    vec_nxt_s   = vec_idx_r + IN_W'(1'b1);
                    stim_nxt_s  = stim_map(vec_idx_r + IN_W'(1'b1));
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s == APPLY) || (state_nxt_s == WAIT) || (state_nxt_s == CAPTURE);
        done_nxt_s = (state_nxt_s == DONE);
        pass_nxt_s = done_nxt_s && (sig_nxt_s == GOLDEN);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            vec_idx_r  <= {IN_W{1'b0}};
            stim_r     <= {IN_W{1'b0}};
            sig_r      <= SEED;
            wait_cnt_r <= 4'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            vec_idx_r  <= vec_nxt_s;
            stim_r     <= stim_nxt_s;
            sig_r      <= sig_nxt_s;
            wait_cnt_r <= cnt_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            pass_r     <= pass_nxt_s;
        end
    end

    assign stim      = stim_r;
    assign vec_idx   = vec_idx_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign signature = sig_r;

endmodule

// File: tb/tb_tv_sweep_misr.sv
`timescale 1ns/1ps
// Self-checking bench for tv_sweep_misr: three instances (zero/random LUT, 2-bit loopback,
// and a small logic DUT with fault injection) checked against a behavioural sweep model.
module tb_tv_sweep_misr;

`ifdef TVSWEEP_GRAY_EN
    localparam logic [15:0] GOLD_C  = 16'h0184;
    localparam logic [15:0] FINAL_B = 16'h0000;
`else
    localparam logic [15:0] GOLD_C  = 16'h01D1;
    localparam logic [15:0] FINAL_B = 16'h0003;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_a, start_b, start_c, fault;
    logic [1:0] lut_a [0:7];
    int n_checks = 0;
    int n_fail = 0;

    logic [2:0]  stim_a, vec_a;   logic busy_a, done_a, pass_a; logic [15:0] sig_a; logic [1:0] resp_a;
    logic [1:0]  stim_b, vec_b;   logic busy_b, done_b, pass_b; logic [15:0] sig_b; logic [1:0] resp_b;
    logic [2:0]  stim_c, vec_c;   logic busy_c, done_c, pass_c; logic [15:0] sig_c; logic [1:0] resp_c;

    assign resp_a = lut_a[stim_a];
    assign resp_b = stim_b;
    assign resp_c = {~((stim_c[0] & stim_c[1]) | stim_c[2]), stim_c[0] & stim_c[1]}
                    ^ ((fault && vec_c == 3'd5) ? 2'b01 : 2'b00);

    tv_sweep_misr #(.IN_W(3), .OUT_W(2), .SETTLE(1), .SIG_W(16), .POLY(16'h1021),
                    .SEED(16'h0000), .GOLDEN(16'h0000)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .resp(resp_a), .stim(stim_a), .vec_idx(vec_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a));

    tv_sweep_misr #(.IN_W(2), .OUT_W(2), .SETTLE(0), .SIG_W(16), .POLY(16'h1021),
                    .SEED(16'h0000), .GOLDEN(16'h0003)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .resp(resp_b), .stim(stim_b), .vec_idx(vec_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b));

    tv_sweep_misr #(.IN_W(3), .OUT_W(2), .SETTLE(2), .SIG_W(16), .POLY(16'h1021),
                    .SEED(16'h0000), .GOLDEN(GOLD_C)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .resp(resp_c), .stim(stim_c), .vec_idx(vec_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c));

    // Reference: stimulus order for vector number v
    function automatic int f_map(input int v);
`ifdef TVSWEEP_GRAY_EN
        return v ^ (v / 2);
`else
        return v;
`endif
    endfunction

    // Reference: polynomial signature step using plain integer arithmetic
    function automatic int misr_ref(input int s, input int r);
        int n;
        n = (s * 2) % 65536;
        if (s >= 32768) n = n ^ 32'h1021;
        return n ^ r;
    endfunction

    function automatic int logic_ref(input int v);
        int a, b, c, d, e;
        a = v % 2; b = (v / 2) % 2; c = (v / 4) % 2;
        d = a * b;
        e = (d + c == 0) ? 1 : 0;
        return d + 2 * e;
    endfunction

    function automatic int model_a();
        int s = 0;
        for (int v = 0; v < 8; v++) s = misr_ref(s, int'(lut_a[f_map(v)]));
        return s;
    endfunction

    function automatic int model_c(input bit flt);
        int s = 0;
        for (int v = 0; v < 8; v++) s = misr_ref(s, logic_ref(f_map(v)) ^ ((flt && v == 5) ? 1 : 0));
        return s;
    endfunction

    task automatic run_a(input int inject_k);
        int cycles = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk);
        while (busy_a === 1'b1 && cycles < 100) begin
            n_checks++;
            if (stim_a !== 3'(f_map(cycles / 3)) || vec_a !== 3'(cycles / 3)) begin
                n_fail++;
                $display("FAIL sweep_a_stim cycle %0d: stim=%0d vec=%0d want stim=%0d vec=%0d",
                         cycles, stim_a, vec_a, f_map(cycles / 3), cycles / 3);
            end
            start_a = (cycles == inject_k) ? 1'b1 : 1'b0;
            cycles++;
            @(negedge clk);
        end
        start_a = 1'b0;
        n_checks++;
        if (cycles != 24) begin
            n_fail++;
            $display("FAIL busy_len_a: got %0d cycles want 24", cycles);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; fault = 1'b0;
        for (int i = 0; i < 8; i++) lut_a[i] = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({stim_a, vec_a, busy_a, done_a, pass_a} !== 9'd0 || sig_a !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_a: stim=%0d vec=%0d busy=%b done=%b pass=%b sig=%h want all 0",
                     stim_a, vec_a, busy_a, done_a, pass_a, sig_a);
        end
        n_checks++;
        if ({busy_b, done_b, busy_c, done_c} !== 4'd0 || sig_b !== 16'h0000 || sig_c !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_bc: busy_b=%b done_b=%b busy_c=%b done_c=%b sig_b=%h sig_c=%h want 0",
                     busy_b, done_b, busy_c, done_c, sig_b, sig_c);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_resp;
        for (int i = 0; i < 8; i++) lut_a[i] = 2'b00;
        run_a(-1);
        n_checks++;
        if (done_a !== 1'b1 || pass_a !== 1'b1 || busy_a !== 1'b0 || sig_a !== 16'h0000 || stim_a !== 3'(f_map(7))) begin
            n_fail++;
            $display("FAIL zero_resp_end: done=%b pass=%b busy=%b sig=%h stim=%0d want 1 1 0 0000 %0d",
                     done_a, pass_a, busy_a, sig_a, stim_a, f_map(7));
        end
    endtask

    task automatic test_random_resp;
        int exp;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 8; i++) lut_a[i] = 2'($urandom_range(3));
            exp = model_a();
            run_a(-1);
            n_checks++;
            if (done_a !== 1'b1 || sig_a !== 16'(exp) || pass_a !== (exp == 0)) begin
                n_fail++;
                $display("FAIL random_resp it %0d: done=%b sig=%h pass=%b want 1 %h %b",
                         it, done_a, sig_a, pass_a, 16'(exp), exp == 0);
            end
        end
    endtask

    task automatic test_start_ignored;
        int exp;
        for (int i = 0; i < 8; i++) lut_a[i] = 2'($urandom_range(3));
        exp = model_a();
        run_a(10);
        n_checks++;
        if (done_a !== 1'b1 || sig_a !== 16'(exp)) begin
            n_fail++;
            $display("FAIL start_ignored: done=%b sig=%h want 1 %h", done_a, sig_a, 16'(exp));
        end
    endtask

    task automatic test_restart_from_done;
        int k = 0;
        for (int i = 0; i < 8; i++) lut_a[i] = 2'($urandom_range(3));
        lut_a[f_map(7)] = 2'b01;
        run_a(-1);
        n_checks++;
        if (done_a !== 1'b1 || sig_a !== 16'(model_a()) || pass_a !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_pre: done=%b sig=%h pass=%b want 1 %h 0", done_a, sig_a, pass_a, 16'(model_a()));
        end
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        n_checks++;
        if (done_a !== 1'b0 || pass_a !== 1'b0 || busy_a !== 1'b1 || sig_a !== 16'h0000 || stim_a !== 3'd0) begin
            n_fail++;
            $display("FAIL restart_begin: done=%b pass=%b busy=%b sig=%h stim=%0d want 0 0 1 0000 0",
                     done_a, pass_a, busy_a, sig_a, stim_a);
        end
        while (busy_a === 1'b1 && k < 100) begin k++; @(negedge clk); end
        n_checks++;
        if (k != 24 || done_a !== 1'b1 || sig_a !== 16'(model_a())) begin
            n_fail++;
            $display("FAIL restart_end: busy_cycles=%0d done=%b sig=%h want 24 1 %h", k + 1, done_a, sig_a, 16'(model_a()));
        end
    endtask

    task automatic test_rst_mid_sweep;
        int k = 0;
        for (int i = 0; i < 8; i++) lut_a[i] = 2'($urandom_range(3));
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        while (vec_a !== 3'd4 && k < 100) begin k++; @(negedge clk); end
        n_checks++;
        if (k >= 100) begin
            n_fail++;
            $display("FAIL rst_mid_reach: vec_idx=%0d never reached 4", vec_a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy_a !== 1'b0 || stim_a !== 3'd0 || vec_a !== 3'd0 || sig_a !== 16'h0000 || done_a !== 1'b0 || pass_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: busy=%b stim=%0d vec=%0d sig=%h done=%b pass=%b want 0 0 0 0000 0 0",
                     busy_a, stim_a, vec_a, sig_a, done_a, pass_a);
        end
        run_a(-1);
        n_checks++;
        if (done_a !== 1'b1 || sig_a !== 16'(model_a())) begin
            n_fail++;
            $display("FAIL rst_mid_resweep: done=%b sig=%h want 1 %h", done_a, sig_a, 16'(model_a()));
        end
    endtask

    task automatic test_loopback;
        int seq [4];
        int s = 0;
        int k = 0;
        for (int v = 0; v < 4; v++) begin s = misr_ref(s, f_map(v)); seq[v] = s; end
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        while (busy_b === 1'b1 && k < 50) begin
            if (k % 2 == 0) begin
                n_checks++;
                if (stim_b !== 2'(f_map(k / 2)) || (k >= 2 && sig_b !== 16'(seq[k / 2 - 1]))) begin
                    n_fail++;
                    $display("FAIL loopback_step %0d: stim=%0d sig=%h want stim=%0d", k, stim_b, sig_b, f_map(k / 2));
                end
            end
            k++;
            @(negedge clk);
        end
        n_checks++;
        if (k != 8 || done_b !== 1'b1 || sig_b !== FINAL_B || sig_b !== 16'(seq[3]) || pass_b !== (FINAL_B == 16'h0003)) begin
            n_fail++;
            $display("FAIL loopback_end: cycles=%0d done=%b sig=%h pass=%b want 8 1 %h %b",
                     k, done_b, sig_b, pass_b, FINAL_B, FINAL_B == 16'h0003);
        end
    endtask

    task automatic test_logic_dut;
        int k;
        for (int f = 0; f < 2; f++) begin
            fault = (f == 1);
            k = 0;
            @(negedge clk) start_c = 1'b1;
            @(negedge clk) start_c = 1'b0;
            while (busy_c === 1'b1 && k < 100) begin k++; @(negedge clk); end
            n_checks++;
            if (k != 32 || done_c !== 1'b1 || sig_c !== 16'(model_c(fault)) || pass_c !== (f == 0)) begin
                n_fail++;
                $display("FAIL logic_dut fault=%0d: cycles=%0d done=%b sig=%h pass=%b want 32 1 %h %b",
                         f, k, done_c, sig_c, pass_c, 16'(model_c(fault)), f == 0);
            end
            if (f == 0) begin
                n_checks++;
                if (sig_c !== GOLD_C) begin
                    n_fail++;
                    $display("FAIL logic_golden: sig=%h want %h", sig_c, GOLD_C);
                end
            end
        end
        fault = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_resp();
        test_random_resp();
        test_start_ignored();
        test_restart_from_done();
        test_rst_mid_sweep();
        test_loopback();
        test_logic_dut();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
